// File: rtl/mon_pkg.sv
// Shared types and helpers for the Q mismatch monitor: FSM states,
// synchronizer reset value and a width-generic saturating increment.
package mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2,
      ST_HOLD   = 2'd3
   } mon_state_e;

   localparam logic SYNC_RST_VAL = 1'b1;

   // Callers zero-extend into 64 bits and cast the result back to their width w (w < 64).
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      logic [63:0] lim;
      lim = (64'd1 << w) - 64'd1;
      return (v >= lim) ? lim : v + 64'd1;
   endfunction

endpackage

// File: rtl/q_mismatch_monitor_sync_ff.sv
// Multi-stage input synchronizer; clears to the flip-flop power-up value
// so the compare path never sees X after reset.
module sync_ff
   import mon_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic C,
   input  logic CLR_N,
   input  logic D,
   output logic Q
);

   logic [STAGES-1:0] sr_q;
   logic [STAGES-1:0] sr_d;

   always_comb begin
      sr_d = {sr_q[STAGES-2:0], D};
   end

   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         sr_q <= {STAGES{SYNC_RST_VAL}};
      end else begin
         sr_q <= sr_d;
      end
   end

   assign Q = sr_q[STAGES-1];

endmodule

// File: rtl/q_mismatch_monitor.sv
// Compares N synchronised candidate Qs against a golden Q inside an armed
// window; keeps sticky flags, a saturating error count and first-mismatch info.
module q_mismatch_monitor
   import mon_pkg::*;
#(
   parameter int unsigned N           = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned SETTLE_CYC  = 2,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TS_W        = 16
) (
   input  logic             C,
   input  logic             CLR_N,
   input  logic             CE,
   input  logic             GOLD,
   input  logic [N-1:0]     DUT,
   input  logic             ARM,
   input  logic             STOP,
   input  logic             CLEAR,
   output logic             BUSY,
   output logic             MISMATCH,
   output logic [N-1:0]     MISMATCH_VEC,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic [TS_W-1:0]  FIRST_TS,
   output logic [N-1:0]     FIRST_VEC
);

   logic [N:0]   raw;
   logic [N:0]   synced;
   logic [N-1:0] diff;

   assign raw = {GOLD, DUT};

   for (genvar g = 0; g <= N; g++) begin : g_sync
      sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
         .C    (C),
         .CLR_N(CLR_N),
         .D    (raw[g]),
         .Q    (synced[g])
      );
   end

   assign diff = synced[N-1:0] ^ {N{synced[N]}};

   mon_state_e       state_q,  state_d;
   logic [3:0]       settle_q, settle_d;
   logic [TS_W-1:0]  ts_q,     ts_d;
   logic [N-1:0]     vec_q,    vec_d;
   logic [CNT_W-1:0] err_q,    err_d;
   logic [TS_W-1:0]  fts_q,    fts_d;
   logic [N-1:0]     fvec_q,   fvec_d;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      ts_d     = ts_q;
      vec_d    = vec_q;
      err_d    = err_q;
      fts_d    = fts_q;
      fvec_d   = fvec_q;
      if (CLEAR) begin
         state_d  = ST_IDLE;
         settle_d = '0;
         ts_d     = '0;
         vec_d    = '0;
         err_d    = '0;
         fts_d    = '0;
         fvec_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_HOLD: begin
               if (!STOP && ARM) begin
                  state_d  = ST_SETTLE;
                  settle_d = '0;
                  ts_d     = '0;
                  vec_d    = '0;
                  err_d    = '0;
                  fts_d    = '0;
                  fvec_d   = '0;
               end
            end
            ST_SETTLE: begin
               // Counter counts ignored enabled cycles; leave on the edge that completes them.
               if (STOP) begin
                  state_d = ST_HOLD;
               end else if (SETTLE_CYC == 0) begin
                  state_d = ST_RUN;
               end else if (CE) begin
                  settle_d = settle_q + 4'd1;
                  if (settle_d == 4'(SETTLE_CYC)) begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (CE) begin
                  if (diff != '0) begin
                     err_d = CNT_W'(sat_inc(64'(err_q), CNT_W));
                     vec_d = vec_q | diff;
                     if (vec_q == '0) begin
                        fts_d  = ts_q;
                        fvec_d = diff;
                     end
                  end
                  ts_d = TS_W'(sat_inc(64'(ts_q), TS_W));
               end
               if (STOP) begin
                  state_d = ST_HOLD;
               end
            end
         endcase
      end
   end

   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         ts_q     <= '0;
         vec_q    <= '0;
         err_q    <= '0;
         fts_q    <= '0;
         fvec_q   <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         ts_q     <= ts_d;
         vec_q    <= vec_d;
         err_q    <= err_d;
         fts_q    <= fts_d;
         fvec_q   <= fvec_d;
      end
   end

   assign BUSY         = (state_q == ST_SETTLE) || (state_q == ST_RUN);
   assign MISMATCH     = |vec_q;
   assign MISMATCH_VEC = vec_q;
   assign ERR_CNT      = err_q;
   assign FIRST_TS     = fts_q;
   assign FIRST_VEC    = fvec_q;

endmodule

// File: tb/tb_q_mismatch_monitor.sv
// Scoreboard bench: a cycle-level reference model queues expected results
// per edge; a monitor on the falling edge pops and compares.
module tb_q_mismatch_monitor;

   localparam int unsigned N  = 2;
   localparam int unsigned SS = 2;
   localparam int unsigned SC = 2;
   localparam int unsigned CW = 4;
   localparam int unsigned TW = 8;
   localparam int CNT_MAX = (1 << CW) - 1;
   localparam int TS_MAX  = (1 << TW) - 1;
   localparam int M_IDLE = 0, M_SETTLE = 1, M_RUN = 2, M_HOLD = 3;

   logic          C = 1'b0;
   logic          CLR_N = 1'b0;
   logic          CE = 1'b0;
   logic          GOLD = 1'b0;
   logic [N-1:0]  DUT = '0;
   logic          ARM = 1'b0;
   logic          STOP = 1'b0;
   logic          CLEAR = 1'b0;
   logic          BUSY;
   logic          MISMATCH;
   logic [N-1:0]  MISMATCH_VEC;
   logic [CW-1:0] ERR_CNT;
   logic [TW-1:0] FIRST_TS;
   logic [N-1:0]  FIRST_VEC;

   q_mismatch_monitor #(
      .N(N), .SYNC_STAGES(SS), .SETTLE_CYC(SC), .CNT_W(CW), .TS_W(TW)
   ) u_dut (
      .C(C), .CLR_N(CLR_N), .CE(CE), .GOLD(GOLD), .DUT(DUT), .ARM(ARM),
      .STOP(STOP), .CLEAR(CLEAR), .BUSY(BUSY), .MISMATCH(MISMATCH),
      .MISMATCH_VEC(MISMATCH_VEC), .ERR_CNT(ERR_CNT), .FIRST_TS(FIRST_TS),
      .FIRST_VEC(FIRST_VEC)
   );

   always #5 C = ~C;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: window state as the spec's named modes, inputs delayed by SS edges.
   typedef struct {
      bit         busy;
      bit [N-1:0] vec;
      int         err;
      int         fts;
      bit [N-1:0] fvec;
   } exp_t;

   int         m_mode, m_rem, m_ts, m_err, m_fts;
   bit [N-1:0] m_vec, m_fvec;
   bit [N:0]   pipe[$];
   exp_t       exp_q[$];

   task automatic model_zero();
      m_ts = 0; m_err = 0; m_fts = 0; m_vec = '0; m_fvec = '0;
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_rem = 0;
      model_zero();
      pipe.delete();
      for (int i = 0; i < int'(SS); i++) pipe.push_back('1);
   endtask

   function automatic exp_t snap();
      exp_t s;
      s.busy = (m_mode == M_SETTLE) || (m_mode == M_RUN);
      s.vec  = m_vec;
      s.err  = m_err;
      s.fts  = m_fts;
      s.fvec = m_fvec;
      return s;
   endfunction

   task automatic model_step();
      bit [N:0]   cur;
      bit [N-1:0] diff;
      cur = pipe.pop_front();
      pipe.push_back({GOLD, DUT});
      diff = cur[N-1:0] ^ {N{cur[N]}};
      if (CLEAR) begin
         m_mode = M_IDLE;
         model_zero();
      end else begin
         case (m_mode)
            M_IDLE, M_HOLD:
               if (!STOP && ARM) begin
                  model_zero();
                  m_mode = M_SETTLE;
                  m_rem  = SC;
               end
            M_SETTLE:
               if (STOP) m_mode = M_HOLD;
               else if (m_rem == 0) m_mode = M_RUN;
               else if (CE) begin
                  m_rem--;
                  if (m_rem == 0) m_mode = M_RUN;
               end
            default: begin
               if (CE) begin
                  if (diff != '0) begin
                     if (m_vec == '0) begin
                        m_fts  = m_ts;
                        m_fvec = diff;
                     end
                     m_vec = m_vec | diff;
                     if (m_err < CNT_MAX) m_err++;
                  end
                  if (m_ts < TS_MAX) m_ts++;
               end
               if (STOP) m_mode = M_HOLD;
            end
         endcase
      end
   endtask

   initial forever begin
      @(posedge C or negedge CLR_N);
      if (!CLR_N) begin
         model_reset();
         exp_q.delete();
         exp_q.push_back(snap());
      end else begin
         model_step();
         exp_q.push_back(snap());
      end
   end

   initial forever begin
      exp_t e;
      @(negedge C);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("busy",      BUSY,         e.busy);
         check("mismatch",  MISMATCH,     (e.vec != '0));
         check("mis_vec",   MISMATCH_VEC, e.vec);
         check("err_cnt",   ERR_CNT,      e.err);
         check("first_ts",  FIRST_TS,     e.fts);
         check("first_vec", FIRST_VEC,    e.fvec);
      end
   end

   task automatic cyc(input bit ce, input bit g, input bit [N-1:0] d,
                      input bit arm = 1'b0, input bit stop = 1'b0, input bit clr = 1'b0);
      @(negedge C);
      #1;
      CE = ce; GOLD = g; DUT = d; ARM = arm; STOP = stop; CLEAR = clr;
   endtask

   task automatic eq(input bit ce, input bit arm = 1'b0, input bit stop = 1'b0);
      bit g;
      g = 1'($urandom_range(0, 1));
      cyc(ce, g, {N{g}}, arm, stop);
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_busy"},  BUSY, 0);
      check({tag, "_mis"},   MISMATCH, 0);
      check({tag, "_vec"},   MISMATCH_VEC, 0);
      check({tag, "_err"},   ERR_CNT, 0);
      check({tag, "_fts"},   FIRST_TS, 0);
      check({tag, "_fvec"},  FIRST_VEC, 0);
   endtask

   initial begin
      #2 chk_zero("por");
      repeat (3) @(negedge C);
      #1 CLR_N = 1'b1;

      // Clean window, then frozen results after STOP.
      eq(1, 1);
      repeat (100) eq(1);
      eq(1, 0, 1);
      repeat (20) eq(1'($urandom_range(0, 1)));

      // Single-candidate error burst on DUT[1].
      eq(1, 1);
      repeat (SS + SC + 10) eq(1);
      repeat (3) cyc(1, 1'b0, 2'b10);
      repeat (10) eq(1);
      eq(1, 0, 1);

      // Settle masking with CE gaps while the mismatch is present.
      cyc(1, 1'b0, 2'b11, 1);
      cyc(0, 1'b0, 2'b11);
      cyc(1, 1'b0, 2'b11);
      cyc(0, 1'b0, 2'b00);
      cyc(1, 1'b0, 2'b00);
      repeat (6) cyc(1, 1'b0, 2'b00);

      // Asynchronous GOLD pulses: DUT[0] follows, DUT[1] stays low.
      @(negedge C); #1 GOLD = 1'b1; DUT = 2'b01;
      #3 GOLD = 1'b0; DUT = 2'b00;
      repeat (4) cyc(1, 1'b0, 2'b00);
      @(negedge C); #3 GOLD = 1'b1; DUT = 2'b01;
      @(posedge C); #3 GOLD = 1'b0; DUT = 2'b00;
      repeat (4) cyc(1, 1'b0, 2'b00);
      eq(1, 0, 1);

      // Error counter saturation, then STOP+CLEAR on the same edge.
      eq(1, 1);
      repeat (24) cyc(1, 1'b1, 2'b01);
      repeat (3) eq(1);
      cyc(1, 1'b0, 2'b00, 0, 1, 1);
      repeat (3) eq(1);

      // ARM from HOLD restarts the window and captures a new FIRST_TS.
      eq(1, 1);
      repeat (8) eq(1);
      repeat (2) cyc(1, 1'b1, 2'b10);
      eq(1, 0, 1);
      repeat (3) eq(1);
      eq(1, 1);
      repeat (12) eq(1);
      cyc(1, 1'b0, 2'b01);
      repeat (4) eq(1);
      eq(1, 0, 1);

      // Timestamp saturation before the first mismatch.
      eq(1, 1);
      repeat (300) eq(1);
      cyc(1, 1'b1, 2'b00);
      repeat (4) eq(1);
      eq(1, 0, 1);

      // Randomised commands, enables and mismatches.
      for (int i = 0; i < 400; i++) begin
         bit g;
         bit [N-1:0] d;
         g = 1'($urandom_range(0, 1));
         d = {N{g}};
         if ($urandom_range(0, 5) == 0) d = d ^ N'($urandom_range(1, (1 << N) - 1));
         cyc(($urandom_range(0, 3) != 0), g, d, ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0));
      end

      // Asynchronous reset in the middle of a window holding 5 errors.
      eq(1, 0, 0);
      cyc(1, 1'b0, 2'b00, 0, 0, 1);
      eq(1, 1);
      repeat (6) eq(1);
      repeat (5) cyc(1, 1'b1, 2'b00);
      repeat (4) eq(1);
      @(posedge C); #2 CLR_N = 1'b0;
      #1 chk_zero("async_rst");
      @(negedge C); #1 CLR_N = 1'b1;
      eq(1, 1);
      @(posedge C); #1 check("busy_after_arm", BUSY, 1);
      repeat (5) eq(1);

      repeat (3) @(negedge C);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
